// File: rtl/ascon_pack.sv
// Shared definitions for the ASCON control path: FSM states and permutation round bounds.
package ascon_pack;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_t;

  localparam int          NB_ROUNDS_A   = 12;
  localparam logic [3:0]  ROUND_B_START = 4'd6;  // p^b runs the last 6 round constants

endpackage

// File: rtl/ascon_fsm_ctrl_round_counter.sv
// Round-constant index counter: load 0 for p^a, load 6 for p^b, then count up and stop at LAST.
module round_counter
  import ascon_pack::*;
#(
  parameter logic [3:0] LAST = 4'd11
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       init_a,
  input  logic       init_b,
  input  logic       en,
  output logic [3:0] round
);

  logic [3:0] r_round;

  always_ff @(posedge clock_i) begin
    if (reset_i)                     r_round <= 4'd0;
    else if (init_a)                 r_round <= 4'd0;
    else if (init_b)                 r_round <= ROUND_B_START;
    else if (en && r_round != LAST)  r_round <= r_round + 4'd1;
  end

  assign round = r_round;

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// ASCON AEAD control FSM: sequences init, associated data, plaintext blocks and finalization,
// and decodes the datapath mux/xor/enable controls from state and round index.
module ascon_fsm_ctrl #(
  parameter int NB_PT_BLOCKS = 4,
  parameter int NB_ROUNDS_A  = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       xor_begin_data_o,
  output logic       xor_begin_key_o,
  output logic       bypass_xor_end_o,
  output logic       mode_xor_key_o,
  output logic       en_state_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       end_o
);
  import ascon_pack::*;

  localparam int             BW       = (NB_PT_BLOCKS > 1) ? $clog2(NB_PT_BLOCKS) : 1;
  localparam logic [3:0]     RND_LAST = 4'(NB_ROUNDS_A - 1);
  localparam logic [BW-1:0]  BLK_LAST = BW'(NB_PT_BLOCKS - 1);

  state_t        r_state, w_next;
  logic [BW-1:0] r_block;
  logic          r_cipher_valid;
  logic [3:0]    w_round;
  logic          w_last, w_init_a, w_init_b, w_en_rnd, w_blk_clr, w_blk_inc;

  round_counter #(.LAST(RND_LAST)) u_round (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .init_a  (w_init_a),
    .init_b  (w_init_b),
    .en      (w_en_rnd),
    .round   (w_round)
  );

  assign w_last = (w_round == RND_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state        <= S_IDLE;
      r_block        <= '0;
      r_cipher_valid <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cipher_valid <= en_cipher_o;
      if (w_blk_clr)      r_block <= '0;
      else if (w_blk_inc) r_block <= r_block + 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_init_a  = 1'b0;
    w_init_b  = 1'b0;
    w_en_rnd  = 1'b0;
    w_blk_clr = 1'b0;
    w_blk_inc = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) begin w_next = S_INIT; w_init_a = 1'b1; end
      S_INIT: begin
        w_en_rnd = 1'b1;
        if (w_last) w_next = S_WAIT_AD;
      end
      S_WAIT_AD: if (data_valid_i) begin w_next = S_AD; w_init_b = 1'b1; end
      S_AD: begin
        w_en_rnd = 1'b1;
        if (w_last) begin w_next = S_WAIT_PT; w_blk_clr = 1'b1; end
      end
      // The last plaintext block is absorbed by the finalization permutation itself.
      S_WAIT_PT: if (data_valid_i) begin
        if (r_block == BLK_LAST) begin w_next = S_FINAL; w_init_a = 1'b1; end
        else                     begin w_next = S_PT;    w_init_b = 1'b1; end
      end
      S_PT: begin
        w_en_rnd = 1'b1;
        if (w_last) begin w_next = S_WAIT_PT; w_blk_inc = 1'b1; end
      end
      S_FINAL: begin
        w_en_rnd = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sel_init_o       = 1'b0;
    xor_begin_data_o = 1'b0;
    xor_begin_key_o  = 1'b0;
    bypass_xor_end_o = 1'b1;
    mode_xor_key_o   = 1'b0;
    en_state_o       = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    case (r_state)
      S_IDLE: mode_xor_key_o = 1'b1;
      S_INIT: begin
        en_state_o = 1'b1;
        sel_init_o = (w_round == 4'd0);
        if (w_last) begin bypass_xor_end_o = 1'b0; mode_xor_key_o = 1'b1; end
      end
      S_AD: begin
        en_state_o       = 1'b1;
        xor_begin_data_o = (w_round == ROUND_B_START);
        if (w_last) bypass_xor_end_o = 1'b0;
      end
      S_PT: begin
        en_state_o = 1'b1;
        if (w_round == ROUND_B_START) begin xor_begin_data_o = 1'b1; en_cipher_o = 1'b1; end
      end
      S_FINAL: begin
        en_state_o = 1'b1;
        if (w_round == 4'd0) begin
          xor_begin_data_o = 1'b1;
          xor_begin_key_o  = 1'b1;
          en_cipher_o      = 1'b1;
        end
        if (w_last) begin bypass_xor_end_o = 1'b0; mode_xor_key_o = 1'b1; en_tag_o = 1'b1; end
      end
      default: ;
    endcase
  end

  assign round_o        = w_round;
  assign cipher_valid_o = r_cipher_valid;
  assign busy_o         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign end_o          = (r_state == S_DONE);

endmodule
